ctrl_pipe_bp: RTL and testbench

Multi-stage valid/ready pipeline register with full-throughput backpressure. Data moves forward and `ready` moves backward through `STG_NUM` registered stages. Every path between the upstream and downstream interfaces is broken by a flop, so neither side sees a combinational path to the other. Used in the control datapath wherever a fixed register delay must also tolerate downstream stalls without losing or duplicating words.

---
 rtl/ctrl_pkg.sv | 19 +
 rtl/ctrl_skid_stage.sv | 97 +++++++++
 rtl/ctrl_pipe_bp.sv | 94 +++++++++
 tb/tb_ctrl_pipe_bp.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_pkg
// Description : Shared definitions for the control-path pipeline blocks.
//               Holds the per-stage state encoding used by ctrl_skid_stage.
// Revision    : 1.0 - initial release
// ============================================================================
package ctrl_pkg;

  // Skid stage states
  //   EMPTY : nothing stored
  //   BUSY  : main register holds a word
  //   FULL  : main and skid registers both hold a word
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

endpackage
`default_nettype wire

// File: rtl/ctrl_skid_stage.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_skid_stage
// Description : One registered valid/ready stage with a skid register.
//               Accepts a word per cycle, can absorb one extra word when the
//               downstream stalls, and exposes only flop outputs.
// Ports       : clk, rst (async, active-high), flush (sync clear)
//               in_valid/in_ready/in_data   - upstream handshake
//               out_valid/out_ready/out_data - downstream handshake
// Revision    : 1.0 - initial release
// ============================================================================
module ctrl_skid_stage #(
  parameter int DWID = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DWID-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DWID-1:0] out_data
);
  import ctrl_pkg::*;

  logic [1:0]      state_q, state_d;
  logic [DWID-1:0] main_q,  main_d;
  logic [DWID-1:0] skid_q,  skid_d;

  logic w_in_fire;
  logic w_out_fire;

  // Both handshake outputs come straight from the state register, so the
  // upstream ready never depends combinationally on out_ready.
  assign in_ready   = (state_q != ST_FULL);
  assign out_valid  = (state_q != ST_EMPTY);
  assign out_data   = main_q;

  assign w_in_fire  = in_valid  & in_ready;
  assign w_out_fire = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (w_in_fire) begin
          state_d = ST_BUSY;
          main_d  = in_data;
        end
      end
      ST_BUSY: begin
        if (w_in_fire && w_out_fire) begin
          main_d  = in_data;
        end else if (w_in_fire) begin
          // Downstream stalled: park the new word behind the main one.
          state_d = ST_FULL;
          skid_d  = in_data;
        end else if (w_out_fire) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // in_ready is low here, so only the drain transition exists.
        if (w_out_fire) begin
          state_d = ST_BUSY;
          main_d  = skid_q;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase

    // Flush overrides any fire in the same cycle; data registers are left
    // as-is since they are invisible while the stage is EMPTY.
    if (flush) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ctrl_pipe_bp.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_pipe_bp
// Description : Multi-stage valid/ready pipeline register with full-throughput
//               backpressure. STG_NUM chained skid stages give a fixed
//               STG_NUM-cycle latency, a capacity of 2*STG_NUM words and no
//               combinational path between the upstream and downstream sides.
// Ports       : clk, rst (async, active-high), flush (sync clear)
//               s_valid/s_ready/s_data - upstream handshake
//               m_valid/m_ready/m_data - downstream handshake
//               occ                    - words accepted and not yet delivered
// Revision    : 1.0 - initial release
// ============================================================================
module ctrl_pipe_bp #(
  parameter int DWID    = 10,
  parameter int STG_NUM = 1,
  parameter int OWID    = $clog2(2*STG_NUM+1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [DWID-1:0] s_data,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [DWID-1:0] m_data,
  output logic [OWID-1:0] occ
);
  import ctrl_pkg::*;

  // Inter-stage links: index i is the input side of stage i, index STG_NUM
  // is the downstream interface.
  logic            w_vld  [STG_NUM+1];
  logic            w_rdy  [STG_NUM+1];
  logic [DWID-1:0] w_data [STG_NUM+1];

  assign w_vld[0]       = s_valid;
  assign w_data[0]      = s_data;
  assign s_ready        = w_rdy[0];

  assign m_valid        = w_vld[STG_NUM];
  assign m_data         = w_data[STG_NUM];
  assign w_rdy[STG_NUM] = m_ready;

  generate
    for (genvar gi = 0; gi < STG_NUM; gi++) begin : g_stage
      ctrl_skid_stage #(
        .DWID (DWID)
      ) u_stage (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (w_vld[gi]),
        .in_ready  (w_rdy[gi]),
        .in_data   (w_data[gi]),
        .out_valid (w_vld[gi+1]),
        .out_ready (w_rdy[gi+1]),
        .out_data  (w_data[gi+1])
      );
    end
  endgenerate

  // Occupancy counter tracks end-to-end fires. It cannot overflow because
  // s_ready is low whenever all 2*STG_NUM slots are in use.
  logic            w_s_fire;
  logic            w_m_fire;
  logic [OWID-1:0] occ_q, occ_d;

  assign w_s_fire = s_valid & s_ready;
  assign w_m_fire = m_valid & m_ready;
  assign occ      = occ_q;

  always_comb begin
    occ_d = occ_q;
    if (flush) begin
      occ_d = '0;
    end else if (w_s_fire && !w_m_fire) begin
      occ_d = occ_q + OWID'(1);
    end else if (!w_s_fire && w_m_fire) begin
      occ_d = occ_q - OWID'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ctrl_pipe_bp.sv
`default_nettype none
// ============================================================================
// Module      : tb_ctrl_pipe_bp
// Description : Self-checking bench for ctrl_pipe_bp. Main instance uses
//               STG_NUM=2 with a queue scoreboard; a second STG_NUM=1
//               instance covers the single-stage corner.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ctrl_pipe_bp;
  localparam int DWID = 10;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush;

  // STG_NUM = 2 instance
  logic            s_valid, s_ready;
  logic [DWID-1:0] s_data;
  logic            m_valid, m_ready;
  logic [DWID-1:0] m_data;
  logic [2:0]      occ;

  // STG_NUM = 1 instance
  logic            u1_s_valid, u1_s_ready;
  logic [DWID-1:0] u1_s_data;
  logic            u1_m_valid, u1_m_ready;
  logic [DWID-1:0] u1_m_data;
  logic [1:0]      u1_occ;

  int checks = 0;
  int errors = 0;
  int rx_cnt = 0;
  logic [DWID-1:0] sb [$];

  always #5 clk = ~clk;

  ctrl_pipe_bp #(.DWID(DWID), .STG_NUM(2)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .occ(occ)
  );

  ctrl_pipe_bp #(.DWID(DWID), .STG_NUM(1)) dut1 (
    .clk(clk), .rst(rst), .flush(flush),
    .s_valid(u1_s_valid), .s_ready(u1_s_ready), .s_data(u1_s_data),
    .m_valid(u1_m_valid), .m_ready(u1_m_ready), .m_data(u1_m_data),
    .occ(u1_occ)
  );

  // One clock cycle for the main instance. Handshakes are evaluated at the
  // falling edge (inputs were driven 1ns after the previous rising edge), the
  // scoreboard is updated, then control returns 1ns after the next rising edge.
  task automatic tick();
    logic [DWID-1:0] exp_w;
    @(negedge clk);
    checks++;
    if (occ !== 3'(sb.size())) begin
      errors++;
      $display("FAIL occ_track: got %0d expected %0d", occ, sb.size());
    end
    if (m_valid === 1'b1 && m_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_word: got %h expected none", m_data);
      end else begin
        exp_w = sb.pop_front();
        rx_cnt++;
        if (m_data !== exp_w) begin
          errors++;
          $display("FAIL order: got %h expected %h", m_data, exp_w);
        end
      end
    end
    if (flush) sb.delete();
    else if (s_valid && s_ready === 1'b1) sb.push_back(s_data);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    m_ready = 1'b1;
    s_valid = 1'b0;
    for (int c = 0; c < 20 && sb.size() > 0; c++) tick();
    tick();
    checks++;
    if (m_valid !== 1'b0 || occ !== 3'd0) begin
      errors++;
      $display("FAIL drain: got m_valid=%b occ=%0d expected m_valid=0 occ=0", m_valid, occ);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    checks++;
    if (m_valid !== 1'b0 || m_data !== '0 || occ !== 3'd0 || s_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: got m_valid=%b m_data=%h occ=%0d s_ready=%b expected 0,000,0,1",
               m_valid, m_data, occ, s_ready);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_streaming();
    m_ready = 1'b1;
    for (int j = 1; j <= 10; j++) begin
      s_valid = (j <= 8);
      s_data  = DWID'(j);
      if (j <= 8) begin
        checks++;
        if (s_ready !== 1'b1) begin
          errors++;
          $display("FAIL stream_s_ready: got %b expected 1 (word %0d)", s_ready, j);
        end
      end
      checks++;
      if (j >= 3) begin
        if (m_valid !== 1'b1 || m_data !== DWID'(j-2)) begin
          errors++;
          $display("FAIL stream_latency: got v=%b d=%h expected v=1 d=%h", m_valid, m_data, DWID'(j-2));
        end
      end else if (m_valid !== 1'b0) begin
        errors++;
        $display("FAIL stream_latency: got v=%b expected v=0 at cycle %0d", m_valid, j);
      end
      tick();
    end
    s_valid = 1'b0;
    checks++;
    if (m_valid !== 1'b0) begin
      errors++;
      $display("FAIL stream_end: got m_valid=%b expected 0", m_valid);
    end
  endtask

  task automatic test_stall();
    logic [DWID-1:0] nxt;
    logic            r;
    int              acc;
    int              first;
    nxt = 10'h010;
    acc = 0;
    m_ready = 1'b0;
    s_valid = 1'b1;
    for (int c = 0; c < 8; c++) begin
      s_data = nxt;
      r = s_ready;
      checks++;
      if (r !== (c < 4)) begin
        errors++;
        $display("FAIL stall_s_ready: got %b expected %b at cycle %0d", r, (c < 4), c);
      end
      tick();
      if (r) begin nxt++; acc++; end
    end
    checks++;
    if (acc != 4 || occ !== 3'd4 || m_data !== 10'h010) begin
      errors++;
      $display("FAIL stall_full: got acc=%0d occ=%0d head=%h expected 4,4,010", acc, occ, m_data);
    end
    m_ready = 1'b1;
    first = -1;
    for (int c = 0; c < 14; c++) begin
      s_valid = (nxt <= 10'h017);
      s_data  = nxt;
      r = s_ready;
      if (first < 0 && r) first = c;
      tick();
      if (r && s_valid) nxt++;
    end
    checks++;
    if (first < 0 || first > 2) begin
      errors++;
      $display("FAIL stall_release: got s_ready after %0d cycles expected <=2", first);
    end
    drain();
  endtask

  task automatic test_toggle();
    logic [DWID-1:0] nxt;
    logic            r;
    int              sent;
    int              base;
    nxt  = 10'h100;
    sent = 0;
    base = rx_cnt;
    for (int c = 0; c < 400 && sent < 64; c++) begin
      m_ready = (c % 2 == 0);
      s_valid = 1'b1;
      s_data  = nxt;
      r = s_ready;
      tick();
      if (r) begin nxt++; sent++; end
    end
    drain();
    checks++;
    if (rx_cnt - base != 64) begin
      errors++;
      $display("FAIL toggle_count: got %0d words expected 64", rx_cnt - base);
    end
  endtask

  task automatic test_flush();
    m_ready = 1'b0;
    s_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      s_data = 10'h050 + DWID'(k);
      tick();
    end
    s_valid = 1'b0;
    checks++;
    if (occ !== 3'd3) begin
      errors++;
      $display("FAIL flush_pre: got occ=%0d expected 3", occ);
    end
    flush   = 1'b1;
    s_valid = 1'b1;
    s_data  = 10'h2AA;
    tick();
    flush   = 1'b0;
    s_valid = 1'b0;
    checks++;
    if (m_valid !== 1'b0 || occ !== 3'd0 || s_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_clear: got m_valid=%b occ=%0d s_ready=%b expected 0,0,1", m_valid, occ, s_ready);
    end
    m_ready = 1'b1;
    repeat (4) tick();
  endtask

  task automatic test_async_reset();
    logic [DWID-1:0] nxt;
    logic            r;
    nxt = 10'h060;
    m_ready = 1'b0;
    s_valid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      s_data = nxt;
      r = s_ready;
      tick();
      if (r) nxt++;
    end
    checks++;
    if (occ !== 3'd4) begin
      errors++;
      $display("FAIL areset_pre: got occ=%0d expected 4", occ);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (m_valid !== 1'b0 || m_data !== '0 || occ !== 3'd0 || s_ready !== 1'b1) begin
      errors++;
      $display("FAIL areset_now: got m_valid=%b m_data=%h occ=%0d s_ready=%b expected 0,000,0,1",
               m_valid, m_data, occ, s_ready);
    end
    sb.delete();
    s_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    test_streaming();
  endtask

  task automatic test_stg1();
    logic [DWID-1:0] nxt;
    logic            r;
    int              acc;
    nxt = 10'h300;
    acc = 0;
    u1_m_ready = 1'b0;
    u1_s_valid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      u1_s_data = nxt;
      @(negedge clk);
      r = u1_s_ready;
      @(posedge clk);
      #1;
      if (r) begin acc++; nxt++; end
    end
    checks++;
    if (acc != 2 || u1_occ !== 2'd2 || u1_s_ready !== 1'b0 || u1_m_data !== 10'h300) begin
      errors++;
      $display("FAIL stg1_stall: got acc=%0d occ=%0d s_ready=%b head=%h expected 2,2,0,300",
               acc, u1_occ, u1_s_ready, u1_m_data);
    end
    u1_s_valid = 1'b0;
    u1_m_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if (u1_m_valid !== 1'b1 || u1_m_data !== 10'h300 + DWID'(k)) begin
        errors++;
        $display("FAIL stg1_drain: got v=%b d=%h expected v=1 d=%h", u1_m_valid, u1_m_data, 10'h300 + DWID'(k));
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (u1_m_valid !== 1'b0 || u1_occ !== 2'd0) begin
      errors++;
      $display("FAIL stg1_empty: got v=%b occ=%0d expected 0,0", u1_m_valid, u1_occ);
    end
    u1_s_valid = 1'b1;
    u1_s_data  = 10'h3A5;
    @(posedge clk);
    #1;
    u1_s_valid = 1'b0;
    checks++;
    if (u1_m_valid !== 1'b1 || u1_m_data !== 10'h3A5 || u1_occ !== 2'd1) begin
      errors++;
      $display("FAIL stg1_latency: got v=%b d=%h occ=%0d expected 1,3A5,1", u1_m_valid, u1_m_data, u1_occ);
    end
    @(posedge clk);
    #1;
    u1_m_ready = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    flush      = 1'b0;
    s_valid    = 1'b0;
    s_data     = '0;
    m_ready    = 1'b0;
    u1_s_valid = 1'b0;
    u1_s_data  = '0;
    u1_m_ready = 1'b0;

    test_reset();
    test_streaming();
    test_stall();
    test_toggle();
    test_flush();
    test_async_reset();
    test_stg1();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected finish before 200000ns");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
